// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin front end for the 64x32 data memory.
// Valid/ready requests, registered response pulses, bounded bus locking.
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_WD,
    input  logic [DATA_W-1:0] mem_RD,

    output logic              lock_active,
    output logic              lock_expired
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // Counter value at which an idle lock owner loses the grant.
    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

    logic [0:0]        state;
    logic [0:0]        state_d;
    logic              busy;

    logic              ptr;
    logic              owner;
    logic              lock_q;
    logic              exp_q;
    logic [7:0]        cnt;

    logic [ADDR_W-1:0] h_addr;
    logic              h_we;
    logic [DATA_W-1:0] h_wdata;
    logic              h_port;

    logic              rv0_q;
    logic              rv1_q;
    logic [DATA_W-1:0] rdata_q;

    logic              rdy0;
    logic              rdy1;
    logic              acc0;
    logic              acc1;
    logic              acc;
    logic              acc_port;
    logic              req_we;
    logic              req_lock;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    assign busy = (state == ACCESS);

    // Grant selection: lock owner only while locked, else sole or ptr port.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (lock_q) begin
            rdy0 = r0_valid & ~owner;
            rdy1 = r1_valid & owner;
        end else begin
            rdy0 = r0_valid & (~r1_valid | ~ptr);
            rdy1 = r1_valid & (~r0_valid | ptr);
        end
    end

    assign acc0     = r0_valid & rdy0;
    assign acc1     = r1_valid & rdy1;
    assign acc      = acc0 | acc1;
    assign acc_port = acc1;

    // Mux the accepted port's request fields toward the hold register.
    always_comb begin
        req_we    = r0_we;
        req_lock  = r0_lock;
        req_addr  = r0_addr;
        req_wdata = r0_wdata;
        if (acc1) begin
            req_we    = r1_we;
            req_lock  = r1_lock;
            req_addr  = r1_addr;
            req_wdata = r1_wdata;
        end
    end

    // Stay in ACCESS while back-to-back requests keep being accepted.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = acc ? ACCESS : IDLE;
            ACCESS:  state_d = acc ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and hold register; the hold register drives the memory.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            h_addr  <= '0;
            h_we    <= 1'b0;
            h_wdata <= '0;
            h_port  <= 1'b0;
        end else begin
            state <= state_d;
            if (acc) begin
                h_addr  <= req_addr;
                h_we    <= req_we;
                h_wdata <= req_wdata;
                h_port  <= acc_port;
            end
        end
    end

    // Response: one-cycle rvalid to the served port; rdata only on reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv0_q <= busy & ~h_port;
            rv1_q <= busy & h_port;
            if (busy && !h_we) begin
                rdata_q <= mem_RD;
            end
        end
    end

    // Lock ownership, hold timeout and round-robin pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_q <= 1'b0;
            owner  <= 1'b0;
            cnt    <= '0;
            exp_q  <= 1'b0;
            ptr    <= 1'b0;
        end else begin
            exp_q <= 1'b0;
            if (acc) begin
                if (req_lock) begin
                    lock_q <= 1'b1;
                    owner  <= acc_port;
                    cnt    <= '0;
                end else begin
                    lock_q <= 1'b0;
                    cnt    <= '0;
                    ptr    <= ~acc_port;
                end
            end else if (lock_q) begin
                if (cnt == LOCK_LAST) begin
                    lock_q <= 1'b0;
                    exp_q  <= 1'b1;
                    cnt    <= '0;
                    ptr    <= ~owner;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    assign r0_ready     = rdy0;
    assign r1_ready     = rdy1;
    assign r0_rvalid    = rv0_q;
    assign r1_rvalid    = rv1_q;
    assign rdata        = rdata_q;
    assign mem_A        = h_addr;
    assign mem_WD       = h_wdata;
    assign mem_WE       = busy & h_we;
    assign lock_active  = lock_q;
    assign lock_expired = exp_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, corner sequences and a random run
// checked against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int ML = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          r0_valid = 1'b0;
    logic          r0_ready;
    logic          r0_we = 1'b0;
    logic          r0_lock = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_rvalid;
    logic          r1_valid = 1'b0;
    logic          r1_ready;
    logic          r1_we = 1'b0;
    logic          r1_lock = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_A;
    logic          mem_WE;
    logic [DW-1:0] mem_WD;
    logic [DW-1:0] mem_RD;
    logic          lock_active;
    logic          lock_expired;

    logic [DW-1:0] mem [64];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_a = '0;
    logic [DW-1:0] bd_d = '0;

    int nvec = 0;
    int nerr = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .CLK(CLK), .RST(RST),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
        .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rvalid(r0_rvalid),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
        .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rvalid(r1_rvalid),
        .rdata(rdata), .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD),
        .mem_RD(mem_RD), .lock_active(lock_active),
        .lock_expired(lock_expired)
    );

    always #5 CLK = ~CLK;

    // Data memory with a backdoor load path for preloading contents.
    always @(posedge CLK) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (mem_WE) mem[mem_A] <= mem_WD;
    end
    assign mem_RD = mem[mem_A];

    typedef struct packed {
        logic          v0, we0, lk0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1, lk1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rdy0, rdy1, rv0, rv1, la;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(
        input logic v0, we0, lk0, input logic [AW-1:0] a0,
        input logic [DW-1:0] d0,
        input logic v1, we1, lk1, input logic [AW-1:0] a1,
        input logic [DW-1:0] d1,
        input logic rdy0, rdy1, rv0, rv1, la, input logic [DW-1:0] rd);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1;
        v.la = la; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_valid = 1'b0; r0_we = 1'b0; r0_lock = 1'b0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_lock = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        bd_a = a; bd_d = d; bd_we = 1'b1;
        @(negedge CLK);
        bd_we = 1'b0;
    endtask

    // Reference model state (transaction level).
    logic [DW-1:0] shadow [64];
    int            g;
    int            mptr, mowner, mage;
    bit            mlock;
    bit            pv, pport, pwe, lk;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwd;
    bit            e_rv0, e_rv1, e_exp;
    logic [DW-1:0] e_rd;
    int            m0, m1, found;
    logic [DW-1:0] d;

    initial begin
        do_reset();
        @(negedge CLK);
        chk("rst_rvalid0", r0_rvalid, 0);
        chk("rst_rvalid1", r1_rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_lock", lock_active, 0);
        chk("rst_expired", lock_expired, 0);
        chk("rst_we", mem_WE, 0);

        // Arbitration and lock table, starting from ptr=0, rdata=0.
        do_reset();
        preload(1, 32'h11);
        preload(2, 32'h22);
        preload(7, 32'h77);
        tbl[0] = mk(1,0,0,1,0, 1,0,0,2,0,     1,0,0,0,0, 32'h0);
        tbl[1] = mk(1,0,0,1,0, 1,0,0,2,0,     0,1,0,0,0, 32'h0);
        tbl[2] = mk(1,0,0,1,0, 1,0,0,2,0,     1,0,1,0,0, 32'h11);
        tbl[3] = mk(1,0,0,1,0, 1,0,0,2,0,     0,1,0,1,0, 32'h22);
        tbl[4] = mk(0,0,0,1,0, 1,0,1,7,0,     0,1,1,0,0, 32'h11);
        tbl[5] = mk(1,0,0,1,0, 0,0,0,7,0,     0,0,0,1,1, 32'h22);
        tbl[6] = mk(1,0,0,1,0, 1,1,0,7,32'h99, 0,1,0,1,1, 32'h77);
        tbl[7] = mk(1,0,0,1,0, 0,0,0,7,0,     1,0,0,0,0, 32'h77);
        tbl[8] = mk(0,0,0,1,0, 0,0,0,7,0,     0,0,0,1,0, 32'h77);
        tbl[9] = mk(0,0,0,1,0, 0,0,0,7,0,     0,0,1,0,0, 32'h11);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            r0_valid = tbl[i].v0; r0_we = tbl[i].we0; r0_lock = tbl[i].lk0;
            r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0;
            r1_valid = tbl[i].v1; r1_we = tbl[i].we1; r1_lock = tbl[i].lk1;
            r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d_ready0", i), r0_ready, tbl[i].rdy0);
            chk($sformatf("tbl%0d_ready1", i), r1_ready, tbl[i].rdy1);
            chk($sformatf("tbl%0d_rvalid0", i), r0_rvalid, tbl[i].rv0);
            chk($sformatf("tbl%0d_rvalid1", i), r1_rvalid, tbl[i].rv1);
            chk($sformatf("tbl%0d_lock", i), lock_active, tbl[i].la);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
        end
        idle_inputs();
        chk("tbl_mem7", mem[7], 32'h99);

        // Single read of a preloaded word.
        do_reset();
        preload(5, 32'hDEADBEEF);
        @(negedge CLK);
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 5;
        #1 chk("rd5_ready", r0_ready, 1);
        @(negedge CLK);
        r0_valid = 1'b0;
        chk("rd5_rvalid_early", r0_rvalid, 0);
        @(negedge CLK);
        chk("rd5_rvalid", r0_rvalid, 1);
        chk("rd5_rdata", rdata, 32'hDEADBEEF);
        @(negedge CLK);
        chk("rd5_rvalid_pulse", r0_rvalid, 0);

        // Write then read of the same address on back-to-back edges.
        @(negedge CLK);
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 3; r0_wdata = 32'h12345678;
        #1 chk("wr3_ready", r0_ready, 1);
        @(negedge CLK);
        r0_we = 1'b0;
        #1 chk("rd3_ready", r0_ready, 1);
        @(negedge CLK);
        r0_valid = 1'b0;
        chk("wr3_ack", r0_rvalid, 1);
        chk("wr3_mem", mem[3], 32'h12345678);
        @(negedge CLK);
        chk("rd3_rvalid", r0_rvalid, 1);
        chk("rd3_rdata", rdata, 32'h12345678);

        // Lock taken by port 1 then abandoned until it times out.
        @(negedge CLK);
        r1_valid = 1'b1; r1_lock = 1'b1; r1_we = 1'b0; r1_addr = 7;
        #1 chk("lk_r1_ready", r1_ready, 1);
        @(posedge CLK);
        @(negedge CLK);
        r1_valid = 1'b0; r1_lock = 1'b0;
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 1;
        #1;
        chk("lk_block_r0", r0_ready, 0);
        chk("lk_active", lock_active, 1);
        found = 0;
        for (int j = 1; j <= 20 && found == 0; j++) begin
            @(posedge CLK);
            #1;
            if (lock_expired) found = j;
        end
        chk("lk_expire_cycle", found, 8);
        chk("lk_released", lock_active, 0);
        chk("lk_r0_granted", r0_ready, 1);
        @(posedge CLK);
        #1 chk("lk_pulse_one", lock_expired, 0);
        @(negedge CLK);
        idle_inputs();

        // Reset while a write is in flight.
        preload(9, 32'hCAFE0009);
        @(negedge CLK);
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 9; r0_wdata = 32'hBAD0BAD0;
        #1 chk("rw_ready", r0_ready, 1);
        @(posedge CLK);
        #2 RST = 1'b1;
        idle_inputs();
        #1 chk("rw_we_drop", mem_WE, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("rw_no_rvalid", r0_rvalid, 0);
        end
        chk("rw_mem_kept", mem[9], 32'hCAFE0009);
        @(negedge CLK);
        r0_valid = 1'b1; r0_addr = 1;
        r1_valid = 1'b1; r1_addr = 2;
        #1;
        chk("rw_ptr0_r0", r0_ready, 1);
        chk("rw_ptr0_r1", r1_ready, 0);
        @(negedge CLK);
        idle_inputs();

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            preload(AW'(i), d);
            shadow[i] = d;
        end
        mptr = 0; mowner = 0; mage = 0; mlock = 0; pv = 0;
        e_rv0 = 0; e_rv1 = 0; e_exp = 0; e_rd = '0;
        m0 = 2; m1 = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            chk("rnd_rvalid0", r0_rvalid, e_rv0);
            chk("rnd_rvalid1", r1_rvalid, e_rv1);
            chk("rnd_rdata", rdata, e_rd);
            chk("rnd_lock", lock_active, mlock);
            chk("rnd_expired", lock_expired, e_exp);
            if (c % 16 == 0) begin
                m0 = $urandom_range(0, 2);
                m1 = $urandom_range(0, 2);
            end
            r0_valid = (m0 == 0) ? 1'b0 :
                       (m0 == 1) ? ($urandom_range(0, 3) == 0) :
                                   ($urandom_range(0, 3) != 0);
            r1_valid = (m1 == 0) ? 1'b0 :
                       (m1 == 1) ? ($urandom_range(0, 3) == 0) :
                                   ($urandom_range(0, 3) != 0);
            r0_we = ($urandom_range(0, 1) == 1);
            r1_we = ($urandom_range(0, 1) == 1);
            r0_lock = ($urandom_range(0, 3) == 0);
            r1_lock = ($urandom_range(0, 3) == 0);
            r0_addr = AW'($urandom_range(0, 7));
            r1_addr = AW'($urandom_range(0, 7));
            r0_wdata = $urandom;
            r1_wdata = $urandom;
            #1;
            if (mlock)
                g = (mowner == 0 && r0_valid) ? 0 :
                    (mowner == 1 && r1_valid) ? 1 : -1;
            else if (r0_valid && r1_valid) g = mptr;
            else if (r0_valid) g = 0;
            else if (r1_valid) g = 1;
            else g = -1;
            chk("rnd_ready0", r0_ready, (g == 0));
            chk("rnd_ready1", r1_ready, (g == 1));
            e_rv0 = 0; e_rv1 = 0; e_exp = 0;
            if (pv) begin
                if (pport == 0) e_rv0 = 1; else e_rv1 = 1;
                if (pwe) shadow[paddr] = pwd;
                else e_rd = shadow[paddr];
            end
            pv = (g >= 0);
            lk = 0;
            if (g == 0) begin
                pport = 0; pwe = r0_we; paddr = r0_addr;
                pwd = r0_wdata; lk = r0_lock;
            end else if (g == 1) begin
                pport = 1; pwe = r1_we; paddr = r1_addr;
                pwd = r1_wdata; lk = r1_lock;
            end
            if (g >= 0) begin
                if (lk) begin
                    mlock = 1; mowner = g; mage = 0;
                end else begin
                    mlock = 0; mptr = 1 - g;
                end
            end else if (mlock) begin
                mage++;
                if (mage == ML) begin
                    mlock = 0; e_exp = 1; mptr = 1 - mowner;
                end
            end
        end
        @(negedge CLK);
        idle_inputs();
        if (pv && pwe) shadow[paddr] = pwd;
        @(negedge CLK);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rnd_mem%0d", i), mem[i], shadow[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
